// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - mode encodings and next-state helpers shared by counter_multimode
//
// Purpose: holds the counting-mode enum, the maximal-length XNOR LFSR tap
// table and the per-mode next-value functions. The helpers work on a 32-bit
// container and take the live width as an argument, so a single definition
// serves every WIDTH in 3..32. Callers zero-extend q and slice the result.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_BIN_UP  = 2'b00,
    MODE_BIN_DN  = 2'b01,
    MODE_LFSR    = 2'b10,
    MODE_JOHNSON = 2'b11
  } mode_e;

  // Mask with the low 'width' bits set.
  function automatic logic [31:0] width_mask(input int unsigned width);
    if (width >= 32) begin
      width_mask = 32'hFFFF_FFFF;
    end else begin
      width_mask = (32'd1 << width) - 32'd1;
    end
  endfunction

  // Maximal-length XNOR feedback taps; bit (n-1) set for tap position n.
  // The all-ones word is the lock-up state for XNOR feedback.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      3:       lfsr_taps = 32'h0000_0006;
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0829;
      13:      lfsr_taps = 32'h0000_100D;
      14:      lfsr_taps = 32'h0000_2015;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_D008;
      17:      lfsr_taps = 32'h0001_2000;
      18:      lfsr_taps = 32'h0002_0400;
      19:      lfsr_taps = 32'h0004_0023;
      20:      lfsr_taps = 32'h0009_0000;
      21:      lfsr_taps = 32'h0014_0000;
      22:      lfsr_taps = 32'h0030_0000;
      23:      lfsr_taps = 32'h0042_0000;
      24:      lfsr_taps = 32'h00E1_0000;
      25:      lfsr_taps = 32'h0120_0000;
      26:      lfsr_taps = 32'h0200_0023;
      27:      lfsr_taps = 32'h0400_0013;
      28:      lfsr_taps = 32'h0900_0000;
      29:      lfsr_taps = 32'h1400_0000;
      30:      lfsr_taps = 32'h2000_0029;
      31:      lfsr_taps = 32'h4800_0000;
      32:      lfsr_taps = 32'h8020_0003;
      default: lfsr_taps = 32'h0000_0000;
    endcase
  endfunction

  // Fibonacci XNOR step: shift left, feed back the XNOR of the tap bits.
  function automatic logic [31:0] lfsr_next(input logic [31:0] q, input int unsigned width);
    logic fb;
    fb = ~(^(q & lfsr_taps(width)));
    lfsr_next = ((q << 1) | {31'd0, fb}) & width_mask(width);
  endfunction

  // Johnson (twisted-ring) step: shift left, feed back the inverted MSB.
  function automatic logic [31:0] johnson_next(input logic [31:0] q, input int unsigned width);
    logic [31:0] msb_vec;
    msb_vec = q >> (width - 32'd1);
    johnson_next = ((q << 1) | {31'd0, ~msb_vec[0]}) & width_mask(width);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - enable-gated clock divider producing advance strobes
//
// Purpose: counts enabled cycles and raises adv on the cycle where the count
// equals prescale, so the owner advances once every prescale+1 enabled cycles.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset
//   en       - count enable; 0 freezes the count
//   clear    - synchronous clear, wins over en and suppresses adv
//   prescale - divide ratio minus 1, compared live every cycle
//   adv      - combinational advance strobe
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  adv
);

  localparam logic [PRESCALE_W-1:0] PS_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] ps_cnt_q;
  logic [PRESCALE_W-1:0] ps_cnt_d;
  logic                  hit;

  // Equality rather than >= on purpose: lowering prescale below the current
  // count lets the count run on and wrap through zero.
  assign hit = (ps_cnt_q == prescale);
  assign adv = en && !clear && hit;

  always_comb begin
    ps_cnt_d = ps_cnt_q;
    if (clear) begin
      ps_cnt_d = '0;
    end else if (en) begin
      ps_cnt_d = hit ? '0 : (ps_cnt_q + PS_ONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_cnt_q <= '0;
    end else begin
      ps_cnt_q <= ps_cnt_d;
    end
  end

endmodule

// File: rtl/counter_multimode.sv
// rtl/counter_multimode.sv - multi-mode counter: binary up/down, LFSR, Johnson
//
// Purpose: single counter channel with prescaler, parallel load, terminal-count
// match, auto-reload or one-shot (sticky done) behaviour.
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous active-low reset
//   en           - count enable
//   load         - single-cycle load strobe (beats any advance that cycle)
//   mode         - counting mode, captured on load
//   auto_reload  - 1 reload load_value at terminal count, 0 one-shot
//   prescale     - advance every prescale+1 enabled cycles
//   load_value   - load and reload value
//   match_value  - terminal-count value
//   q            - counter value
//   tick         - registered pulse after each advance
//   match        - registered pulse after each terminal-count advance
//   done         - sticky one-shot terminal-count flag
module counter_multimode
  import counter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load,
  input  logic [1:0]            mode,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [WIDTH-1:0]      match_value,
  output logic [WIDTH-1:0]      q,
  output logic                  tick,
  output logic                  match,
  output logic                  done
);

  logic [WIDTH-1:0] q_q, q_d;
  mode_e            mode_q, mode_d;
  logic             done_q, done_d;
  logic             tick_q, tick_d;
  logic             match_q, match_d;

  logic             adv;
  logic [31:0]      q_ext;
  logic [31:0]      step32;
  logic [WIDTH-1:0] q_step;
  mode_e            mode_in;

  assign mode_in = mode_e'(mode);

  // Once done is set the prescaler is held too, so no advance (and no tick)
  // can occur until the next load clears done.
  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (en && !done_q),
    .clear    (load),
    .prescale (prescale),
    .adv      (adv)
  );

  // Next value for a normal (non-terminal) advance in the captured mode.
  always_comb begin
    q_ext  = 32'(q_q);
    step32 = q_ext;
    case (mode_q)
      MODE_BIN_UP:  step32 = q_ext + 32'd1;
      MODE_BIN_DN:  step32 = q_ext - 32'd1;
      MODE_LFSR:    step32 = lfsr_next(q_ext, WIDTH);
      MODE_JOHNSON: step32 = johnson_next(q_ext, WIDTH);
      default:      step32 = q_ext;
    endcase
  end

  assign q_step = step32[WIDTH-1:0];

  always_comb begin
    q_d     = q_q;
    mode_d  = mode_q;
    done_d  = done_q;
    tick_d  = 1'b0;
    match_d = 1'b0;
    if (load) begin
      mode_d = mode_in;
      done_d = 1'b0;
      // All-ones is the XNOR lock-up state, so it can never be loaded.
      if ((mode_in == MODE_LFSR) && (&load_value)) begin
        q_d = '0;
      end else begin
        q_d = load_value;
      end
    end else if (adv) begin
      tick_d = 1'b1;
      if (q_q == match_value) begin
        match_d = 1'b1;
        if (auto_reload) begin
          q_d = load_value;
        end else begin
          done_d = 1'b1;
        end
      end else begin
        q_d = q_step;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q     <= '0;
      mode_q  <= MODE_BIN_UP;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
      match_q <= match_d;
    end
  end

  assign q     = q_q;
  assign tick  = tick_q;
  assign match = match_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_multimode.sv
// tb/tb_counter_multimode.sv - self-checking bench for counter_multimode
module tb_counter_multimode;

  localparam int W    = 8;
  localparam int PW   = 8;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          load;
  logic [1:0]    mode;
  logic          auto_reload;
  logic [PW-1:0] prescale;
  logic [W-1:0]  load_value;
  logic [W-1:0]  match_value;
  logic [W-1:0]  q;
  logic          tick;
  logic          match;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state, kept as plain integers.
  int m_q, m_ps, m_mode, m_done, m_tick, m_match;
  int taps [4] = '{8, 6, 5, 4};

  counter_multimode #(
    .WIDTH      (W),
    .PRESCALE_W (PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .load        (load),
    .mode        (mode),
    .auto_reload (auto_reload),
    .prescale    (prescale),
    .load_value  (load_value),
    .match_value (match_value),
    .q           (q),
    .tick        (tick),
    .match       (match),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_next(input int v, input int md);
    int p;
    case (md)
      0: return (v + 1) & MASK;
      1: return (v + MASK) & MASK;
      2: begin
        p = 0;
        foreach (taps[i]) p ^= (v >> (taps[i] - 1)) & 1;
        return ((v << 1) & MASK) | (p ^ 1);
      end
      default: return ((v << 1) & MASK) | (((v >> (W - 1)) & 1) ^ 1);
    endcase
  endfunction

  task automatic model_reset();
    m_q = 0; m_ps = 0; m_mode = 0; m_done = 0; m_tick = 0; m_match = 0;
  endtask

  task automatic model_update();
    if (!reset) begin
      model_reset();
    end else begin
      m_tick  = 0;
      m_match = 0;
      if (load) begin
        m_mode = int'(mode);
        m_q    = (mode == 2'd2 && int'(load_value) == MASK) ? 0 : int'(load_value);
        m_ps   = 0;
        m_done = 0;
      end else if (en && m_done == 0) begin
        if (m_ps == int'(prescale)) begin
          m_ps   = 0;
          m_tick = 1;
          if (m_q == int'(match_value)) begin
            m_match = 1;
            if (auto_reload) m_q = int'(load_value);
            else m_done = 1;
          end else begin
            m_q = model_next(m_q, m_mode);
          end
        end else begin
          m_ps = (m_ps + 1) % (1 << PW);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_eq("q", 32'(q), m_q);
    check_eq("tick", 32'(tick), m_tick);
    check_eq("match", 32'(match), m_match);
    check_eq("done", 32'(done), m_done);
  endtask

  task automatic do_load(input int md, input int lv, input int mv, input int ar, input int ps);
    mode        = md[1:0];
    load_value  = lv[W-1:0];
    match_value = mv[W-1:0];
    auto_reload = ar[0];
    prescale    = ps[PW-1:0];
    load        = 1'b1;
    step();
    load        = 1'b0;
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_q", 32'(q), 0);
    check_eq("rst_tick", 32'(tick), 0);
    check_eq("rst_match", 32'(match), 0);
    check_eq("rst_done", 32'(done), 0);
    model_reset();
    step();
    reset = 1'b1;
  endtask

  initial begin
    int n;
    int first_ret;
    int ones;
    int exp_lfsr [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};

    reset = 1'b1; en = 1'b0; load = 1'b0; mode = 2'd0; auto_reload = 1'b0;
    prescale = '0; load_value = '0; match_value = '0;
    model_reset();
    #1 reset = 1'b0;
    #1;
    check_eq("init_q", 32'(q), 0);
    check_eq("init_done", 32'(done), 0);
    step();
    step();
    reset = 1'b1;
    en = 1'b1;

    // Binary up wrap at match 5 with auto-reload.
    do_load(0, 0, 5, 1, 0);
    check_eq("t1_load_tick", 32'(tick), 0);
    for (int i = 1; i <= 14; i++) begin
      step();
      check_eq("t1_q", 32'(q), i % 6);
      check_eq("t1_match", 32'(match), (i % 6 == 0) ? 1 : 0);
    end

    // Prescale 3, then an en pause of 5 cycles delays the advance by 5.
    do_load(0, 0, 8'hFF, 1, 3);
    for (int i = 1; i <= 12; i++) begin
      step();
      check_eq("t2_tick", 32'(tick), (i % 4 == 0) ? 1 : 0);
      check_eq("t2_q", 32'(q), i / 4);
    end
    n = 0;
    while (n < 30) begin
      en = !(n >= 2 && n < 7);
      step();
      n++;
      if (tick) break;
    end
    en = 1'b1;
    check_eq("t2_pause_gap", n, 9);

    // LFSR: period 255, never all-ones; all-ones load becomes zero.
    do_load(2, 0, 8'hFF, 1, 0);
    first_ret = 0;
    ones = 0;
    for (int i = 1; i <= 255; i++) begin
      step();
      if (i <= 5) check_eq("t3_seq", 32'(q), exp_lfsr[i-1]);
      if (int'(q) == MASK) ones++;
      if (q == '0 && first_ret == 0) first_ret = i;
    end
    check_eq("t3_period", first_ret, 255);
    check_eq("t3_no_ones", ones, 0);
    do_load(2, 8'hFF, 8'h00, 1, 0);
    check_eq("t3_lockup_load", 32'(q), 0);

    // Johnson: period 16 for W=8.
    do_load(3, 0, 8'hAA, 1, 0);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 1)  check_eq("t4_j1", 32'(q), 8'h01);
      if (i == 8)  check_eq("t4_j8", 32'(q), 8'hFF);
      if (i == 9)  check_eq("t4_j9", 32'(q), 8'hFE);
      if (i == 16) check_eq("t4_j16", 32'(q), 8'h00);
    end

    // Binary down one-shot.
    do_load(1, 3, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq("t5_q", 32'(q), 3 - i);
    end
    step();
    check_eq("t5_done", 32'(done), 1);
    check_eq("t5_match", 32'(match), 1);
    check_eq("t5_hold", 32'(q), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t5_no_tick", 32'(tick), 0);
      check_eq("t5_sticky", 32'(done), 1);
    end
    do_load(1, 3, 0, 0, 0);
    check_eq("t5_reload_done", 32'(done), 0);
    check_eq("t5_reload_q", 32'(q), 3);
    step();
    check_eq("t5_resume", 32'(q), 2);

    // Reset mid-count at 0x2A, restart, then load against an advance.
    do_load(0, 8'h20, 8'hFF, 1, 0);
    repeat (10) step();
    check_eq("t6_q2a", 32'(q), 8'h2A);
    async_reset();
    step();
    check_eq("t6_restart", 32'(q), 1);
    do_load(0, 8'h55, 8'hFF, 1, 0);
    check_eq("t6_load_q", 32'(q), 8'h55);
    check_eq("t6_load_tick", 32'(tick), 0);

    // Randomised segments against the reference model.
    for (int seg = 0; seg < 40; seg++) begin
      int md, lv, mv, st;
      md = $urandom_range(0, 3);
      lv = $urandom_range(0, MASK);
      st = (md == 2 && lv == MASK) ? 0 : lv;
      mv = st;
      repeat ($urandom_range(0, 12)) mv = model_next(mv, md);
      if ($urandom_range(0, 3) == 0) mv = $urandom_range(0, MASK);
      en = 1'b1;
      do_load(md, lv, mv, $urandom_range(0, 1), $urandom_range(0, 3));
      for (int c = 0; c < 60; c++) begin
        en   = ($urandom_range(0, 7) != 0);
        mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 63) == 0) prescale = PW'($urandom_range(0, 3));
        load = ($urandom_range(0, 39) == 0);
        if (seg % 8 == 3 && c == 30) async_reset();
        step();
      end
      load = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_multimode.md
Name: counter_multimode

Overview:
Parametrised single-channel counter that generalises the fixed binary, prescaled, LFSR and Johnson counters into one block.
- WIDTH, counting mode and prescale divide are configurable.
- Adds parallel load, terminal-count match, auto-reload and one-shot (sticky done).
- Instantiated per channel in timer and event-counting subsystems on the fabric clock.

Parameters:
WIDTH, 32, counter width in bits; legal 3..32 (LFSR tap table limit).
PRESCALE_W, 16, prescaler width in bits.

Ports:
clk  input  1  counter clock; all state changes on the rising edge.
reset  input  1  asynchronous reset, active-low: assertion clears all state immediately; deassertion takes effect at the next clk edge.
en  input  1  count enable; 0 freezes the prescaler and the counter.
load  input  1  single-cycle load strobe.
mode  input  2  counting mode, captured on load: 00 binary up, 01 binary down, 10 LFSR, 11 Johnson.
auto_reload  input  1  1 = reload load_value at terminal count; 0 = one-shot.
prescale  input  PRESCALE_W  divide ratio minus 1; the counter advances every prescale+1 enabled cycles.
load_value  input  WIDTH  load and reload value.
match_value  input  WIDTH  terminal-count value.
q  output  WIDTH  counter value.
tick  output  1  registered pulse, one cycle after each advance event.
match  output  1  registered pulse, one cycle after each terminal-count event.
done  output  1  sticky terminal-count flag in one-shot mode.

Behaviour:
- Reset (reset=0): q=0, prescaler count=0, tick=0, match=0, done=0, captured mode=binary up.
- Prescaler:
  - ps_cnt increments on each cycle with en=1.
  - Advance event when en=1 and ps_cnt==prescale; ps_cnt then returns to 0.
  - prescale=0 gives an advance every enabled cycle.
  - A change of prescale while running compares against the new value on the next cycle. If ps_cnt already exceeds the new prescale, ps_cnt wraps through 2^PRESCALE_W; this is not corrected.
- Priority, highest first: reset, load, advance, hold.
- Load:
  - q<=load_value, ps_cnt<=0, done<=0, mode captured.
  - No advance, tick or match that cycle, even if en=1.
  - In LFSR mode an all-ones load_value is replaced by 0 (XNOR lockup state).
- Advance with done=1: no change; q and ps_cnt are frozen until load.
- Advance with q==match_value (terminal count):
  - auto_reload=1: q<=load_value.
  - auto_reload=0: q holds and done<=1.
  - match pulses the next cycle.
- Advance otherwise, by captured mode:
  - binary up: q+1, modulo 2^WIDTH.
  - binary down: q-1, modulo 2^WIDTH.
  - LFSR: Fibonacci XNOR, next = {q[WIDTH-2:0], XNOR of tap bits}, taps from the package table. Period 2^WIDTH-1; the all-ones state is never entered.
  - Johnson: next = {q[WIDTH-2:0], ~q[WIDTH-1]}; period 2*WIDTH from any Johnson-valid state.
- tick pulses one cycle after every advance event, including terminal-count events. It does not pulse while done=1.
- Latency: q updates on the advance edge; tick and match are one cycle later.
- en=0 together with load: the load still executes.
- Reset asserted mid-count: immediate clear; counting restarts from 0 in binary up after deassertion and en=1.

Decomposition:
- counter_pkg:
  - mode encodings MODE_BIN_UP, MODE_BIN_DN, MODE_LFSR, MODE_JOHNSON.
  - function lfsr_taps(width) returning the XNOR tap mask for widths 3..32 (max-length table).
  - function lfsr_next and function johnson_next.
- Sub-module counter_prescaler (PRESCALE_W): owns ps_cnt; inputs clk, reset, en, clear (driven by load), prescale; output adv.

Test Plan:
1. WIDTH=8, binary up, load_value=0, match_value=5, auto_reload=1, prescale=0, en=1 -> q sequence 0,1,2,3,4,5,0,1,... ; match pulses once every 6 cycles, one cycle after q=5 goes to 0.
2. Binary up, prescale=3, match_value=0xFF, en=1 -> q increments every 4th cycle; tick pulses every 4 cycles; toggling en low for 5 cycles delays the next advance by exactly 5 cycles.
3. WIDTH=4, LFSR, load 0 -> q 0000,0001,0011,0111,1110,... period 15, never 1111. load_value=1111 -> q=0000.
4. WIDTH=4, Johnson, load 0 -> q 0001,0011,0111,1111,1110,1100,1000,0000, repeating with period 8.
5. Binary down, load_value=3, match_value=0, auto_reload=0 -> q 3,2,1,0 then holds 0; done=1 stays high; no further tick. Then load with load_value=3 -> done=0 and counting resumes.
6. Assert reset mid-count with q=0x2A -> q, tick, match, done all 0 immediately. Assert load in the same cycle as an advance -> q=load_value, no tick.
